// File: rtl/fpu_addsub_seq_if.sv
// Operand/result handshake bundle for the sequential single-precision add/sub unit.
// The master drives operands and result acceptance; the slave is the arithmetic unit.
interface fpu_addsub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 single add/subtract: compare, align one bit per cycle,
// add/subtract, normalise one bit per cycle, pack. Truncating, one op in flight.
module fpu_addsub_seq #(
    parameter int WIDTH     = 24,
    parameter int EXP_W     = 8,
    parameter int ALIGN_MAX = 25
) (
    input  logic               clk,
    input  logic               rst,
    fpu_addsub_seq_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;

    state_t           state_q, state_d;
    logic             sign_a, sign_b, sign_r, eff_sub, special;
    logic [EXP_W-1:0] exp_a, exp_b, exp_r;
    logic [WIDTH-1:0] mant_a, mant_b, mant_l, mant_s;
    logic [4:0]       diff;
    logic [31:0]      result_q;

    logic             a_larger;
    logic [EXP_W-1:0] exp_gap;
    logic [4:0]       diff_cap;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;

    // Ties (equal exponent and mantissa) keep A as the larger operand.
    assign a_larger = {exp_a, mant_a} >= {exp_b, mant_b};
    assign exp_gap  = a_larger ? (exp_a - exp_b) : (exp_b - exp_a);
    assign diff_cap = (exp_gap > EXP_W'(ALIGN_MAX)) ? 5'(ALIGN_MAX) : exp_gap[4:0];
    assign sum      = eff_sub ? ({1'b0, mant_l} - {1'b0, mant_s})
                              : ({1'b0, mant_l} + {1'b0, mant_s});
    assign sum_ovf  = sum[WIDTH] && (exp_r == 8'hFE);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.in_valid) state_d = CMP;
            CMP: begin
                if (special)            state_d = DONE;
                else if (diff_cap == 0) state_d = ADD;
                else                    state_d = ALIGN;
            end
            ALIGN: if (diff == 5'd1) state_d = ADD;
            ADD:   state_d = sum_ovf ? DONE : NORM;
            NORM:  if (mant_l == '0 || mant_l[WIDTH-1] || exp_r == 8'd1) state_d = DONE;
            DONE:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: after CMP the larger operand lives in sign_r/exp_r/mant_l,
    // and mant_l doubles as the working mantissa through ADD and NORM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            sign_r   <= 1'b0;
            eff_sub  <= 1'b0;
            special  <= 1'b0;
            exp_a    <= '0;
            exp_b    <= '0;
            exp_r    <= '0;
            mant_a   <= '0;
            mant_b   <= '0;
            mant_l   <= '0;
            mant_s   <= '0;
            diff     <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    sign_a  <= bus.op_a[31];
                    sign_b  <= bus.op_b[31] ^ bus.op_sub;
                    exp_a   <= bus.op_a[30:23];
                    exp_b   <= bus.op_b[30:23];
                    mant_a  <= (bus.op_a[30:23] == '0) ? '0 : {1'b1, bus.op_a[22:0]};
                    mant_b  <= (bus.op_b[30:23] == '0) ? '0 : {1'b1, bus.op_b[22:0]};
                    special <= (bus.op_a[30:23] == 8'hFF) || (bus.op_b[30:23] == 8'hFF);
                end
                CMP: begin
                    if (special) begin
                        result_q <= 32'h7FC0_0000;
                    end else begin
                        eff_sub <= sign_a ^ sign_b;
                        diff    <= diff_cap;
                        sign_r  <= a_larger ? sign_a : sign_b;
                        exp_r   <= a_larger ? exp_a  : exp_b;
                        mant_l  <= a_larger ? mant_a : mant_b;
                        mant_s  <= a_larger ? mant_b : mant_a;
                    end
                end
                ALIGN: begin
                    mant_s <= mant_s >> 1;
                    diff   <= diff - 5'd1;
                end
                ADD: begin
                    if (sum_ovf) begin
                        result_q <= {sign_r, 8'hFF, 23'd0};
                    end else if (sum[WIDTH]) begin
                        mant_l <= sum[WIDTH:1];
                        exp_r  <= exp_r + 8'd1;
                    end else begin
                        mant_l <= sum[WIDTH-1:0];
                    end
                end
                NORM: begin
                    if (mant_l == '0)           result_q <= 32'd0;
                    else if (mant_l[WIDTH-1])   result_q <= {sign_r, exp_r, mant_l[22:0]};
                    else if (exp_r == 8'd1)     result_q <= 32'd0;
                    else begin
                        mant_l <= mant_l << 1;
                        exp_r  <= exp_r - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed bench for fpu_addsub_seq: hand-computed results and cycle latencies,
// backpressure hold, and reset abort in the middle of alignment.
module tb_fpu_addsub_seq;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fpu_addsub_seq_if bus_if ();

    fpu_addsub_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Issues one operation and waits (bounded) for its result; no comparisons here.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output int lat, output logic [31:0] res);
        bus_if.op_a     = a;
        bus_if.op_b     = b;
        bus_if.op_sub   = sub;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (!bus_if.out_valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus_if.result;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got rdy=%b vld=%b busy=%b expected 1 0 0",
                     bus_if.in_ready, bus_if.out_valid, bus_if.busy);
        end
        checks++;
        if (bus_if.result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_result: got %h expected 00000000", bus_if.result);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic [31:0] res;
        run_op(a, b, sub, lat, res);
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("[TB] FAIL %s result: got %h expected %h", name, res, exp_res);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_busy();
        bus_if.op_a = 32'h3F80_0000; bus_if.op_b = 32'h3F80_0000; bus_if.op_sub = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_after_accept: got busy=%b rdy=%b expected 1 0",
                     bus_if.busy, bus_if.in_ready);
        end
        repeat (3) begin @(posedge clk); #1; end
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int lat = 0;
        bus_if.op_a = 32'h3FC0_0000; bus_if.op_b = 32'h3E80_0000; bus_if.op_sub = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        while (!bus_if.out_valid && lat < LIMIT) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("[TB] FAIL hold_latency: got %0d expected 5", lat);
        end
        bus_if.op_a = 32'h4000_0000; bus_if.op_b = 32'h4000_0000; bus_if.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid !== 1'b1 || bus_if.result !== 32'h3FE0_0000 || bus_if.in_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0 (vld=%b res=%h rdy=%b)",
                     bad, bus_if.out_valid, bus_if.result, bus_if.in_ready);
        end
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: got vld=%b rdy=%b expected 0 1",
                     bus_if.out_valid, bus_if.in_ready);
        end
    endtask

    task automatic test_reset_abort();
        bus_if.op_a = 32'h3FC0_0000; bus_if.op_b = 32'h3E80_0000; bus_if.op_sub = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0 ||
            bus_if.result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL abort_reset: got rdy=%b vld=%b busy=%b res=%h expected 1 0 0 00000000",
                     bus_if.in_ready, bus_if.out_valid, bus_if.busy, bus_if.result);
        end
        @(negedge clk); rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_no_result: got vld=%b rdy=%b expected 0 1",
                     bus_if.out_valid, bus_if.in_ready);
        end
        test_vector("two_minus_two", 32'h4000_0000, 32'hC000_0000, 1'b0, 32'h0000_0000, 3);
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.op_a      = '0;
        bus_if.op_b      = '0;
        bus_if.op_sub    = 1'b0;
        bus_if.out_ready = 1'b0;
        test_reset();
        test_vector("add_carry",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3);
        test_vector("sub_zero",     32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3);
        test_vector("align2",       32'h3FC0_0000, 32'h3E80_0000, 1'b0, 32'h3FE0_0000, 5);
        test_vector("align2_swap",  32'h3E80_0000, 32'h3FC0_0000, 1'b0, 32'h3FE0_0000, 5);
        test_vector("norm23",       32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3400_0000, 27);
        test_vector("neg_result",   32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 5);
        test_vector("overflow_inf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 2);
        test_vector("special_nan",  32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1);
        test_vector("align_cap",    32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 28);
        test_vector("underflow",    32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h0000_0000, 3);
        test_vector("zero_zero",    32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 3);
        test_busy();
        test_backpressure();
        test_vector("after_hold",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3);
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
